axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-Lite responder (slave end) holding NUM_REGS 32-bit read/write registers.
//  Sits behind one slave port of the AXI4-Lite interconnect and answers its AR/R and AW/W/B traffic.
//  Default map: 16 bytes at BASE_ADDR, matching one interconnect address window.
//  Read and write paths are independent FSMs and may be active in the same cycle.
// PARAMETERS
//  ADDR_WIDTH  32     width of araddr/awaddr
//  DATA_WIDTH  32     register/data width; must be 32
//  NUM_REGS    4      number of registers; power of 2, >= 2
//  BASE_ADDR   32'h0  byte address of reg[0]; aligned to 4*NUM_REGS
// PORTS
//  aclk      in   1           clock, all logic on rising edge
//  areset_n  in   1           asynchronous active-low reset
//  araddr    in   ADDR_WIDTH  read address
//  arvalid   in   1 / arready out 1   AR handshake
//  rdata     out  DATA_WIDTH  read data
//  rresp     out  2           read response
//  rvalid    out  1 / rready in 1     R handshake
//  awaddr    in   ADDR_WIDTH  write address
//  awvalid   in   1 / awready out 1   AW handshake
//  wdata     in   DATA_WIDTH  write data
//  wstrb     in   DATA_WIDTH/8 byte strobes
//  wvalid    in   1 / wready out 1    W handshake
//  bresp     out  2           write response
//  bvalid    out  1 / bready in 1     B handshake
// BEHAVIOUR
//  Reset (areset_n low, async): regs=0; rvalid=bvalid=0; rdata=0; rresp=bresp=OKAY;
//   read FSM in RD_IDLE, write FSM in WR_IDLE. arready=awready=wready=1 after reset.
//   Reset mid-transaction drops the transaction; no response is issued.
//  Decode: idx = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored (no unaligned error).
//  Read FSM RD_IDLE -> RD_RESP on arvalid&&arready. arready = (state==RD_IDLE).
//   At the handshake edge, rdata <= reg[idx] and rvalid <= 1 (1-cycle latency).
//   RD_RESP holds rdata/rresp/rvalid stable until rready, then returns to RD_IDLE.
//   arready is low in RD_RESP, so no back-to-back read before R completes.
//  Write FSM states: WR_IDLE, WR_ADDR (AW held, waiting for W), WR_DATA (W held, waiting for AW), WR_RESP.
//   awready = state in {WR_IDLE, WR_DATA}; wready = state in {WR_IDLE, WR_ADDR}.
//   AW and W are accepted in either order or in the same cycle. Each beat is latched on its handshake.
//   When both are held (or arrive together), the write commits at that edge:
//    byte k of reg[idx] is updated only where wstrb[k]=1. bvalid <= 1 on the same edge (-> WR_RESP).
//   WR_RESP holds bvalid/bresp until bready, then -> WR_IDLE.
//  Simultaneous read and write to the same reg in one cycle: the read returns the pre-write value.
//  rvalid/bvalid never drop without the matching ready. Outputs do not change while valid && !ready.
// CONFIGURATION
//  AXIL_REG_SLV_DECERR_EN defined: idx outside [0, NUM_REGS-1] (addr below BASE_ADDR or at/above
//   BASE_ADDR+4*NUM_REGS) gets DECERR (2'b11). The write is discarded; read gives rdata=0.
//  Not defined: idx is truncated to $clog2(NUM_REGS) bits (aliasing); every response is OKAY.
// STRUCTURE
//  axi_lite_pkg gains: resp codes RESP_OKAY=2'b00 and RESP_DECERR=2'b11, plus state typedefs
//   rd_state_t and wr_state_t.
//  Sub-module axi_lite_reg_slave_wstrb_merge: combinational merge of old reg, wdata and wstrb.
//  Everything else stays in this file.
// TESTING
//  1. Write awaddr=0x4, wdata=0xDEADBEEF, wstrb=4'hF, AW and W in the same cycle, bready=1
//     -> bvalid exactly 1 cycle later with bresp=OKAY; a read of 0x4 returns 0xDEADBEEF with OKAY.
//  2. W sent 3 cycles before AW (addr 0x8, data 0x12345678) -> awready stays high and wready stays
//     low while waiting; reg[2]=0x12345678 after AW.
//  3. Partial write to reg 0 (holding 0xFFFFFFFF) with wdata=0, wstrb=4'b0101 -> read gives 0xFF00FF00.
//  4. Read 0xC with rready held low 5 cycles -> rvalid/rdata stable for all 5; arready=0 until the R handshake.
//  5. Assert areset_n low while in WR_RESP (bvalid=1) -> bvalid=0 immediately without a clock edge;
//     all regs read back 0.
//  6. Access 0x10 with the macro defined -> bresp=DECERR, reg[0] unchanged, rresp=DECERR, rdata=0;
//     without the macro -> aliases to reg[0] with OKAY.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and responder FSM states.
// Used by axi_lite_reg_slave and its helpers.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_reg_slave_wstrb_merge.sv
// Byte-lane merge of write data into an existing register value.
// Lanes with a clear strobe keep the old byte.
module axi_lite_reg_slave_wstrb_merge
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int k = 0; k < DATA_WIDTH/8; k++) begin
      if (wstrb[k]) begin
        merged[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-file responder with independent read and write FSMs.
// Define AXIL_REG_SLV_DECERR_EN to answer out-of-window accesses with DECERR.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH/8;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic wr_commit;

  logic [ADDR_WIDTH-1:0] rd_off;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] wr_off;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  rd_ok;
  logic                  wr_ok;

  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // The beat arriving this cycle wins over the held copy
  assign wr_addr = aw_hs ? awaddr : aw_addr_q;
  assign wr_data = w_hs ? wdata : w_data_q;
  assign wr_strb = w_hs ? wstrb : w_strb_q;

  assign rd_off = araddr - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_idx = wr_off[IDX_W+1:2];

`ifdef AXIL_REG_SLV_DECERR_EN
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4*NUM_REGS);
  // Wrapped subtraction makes addresses below the base look huge
  assign rd_ok = rd_off < SPAN;
  assign wr_ok = wr_off < SPAN;
`else
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
`endif

  logic unused_off;
  assign unused_off = ^{rd_off, wr_off};

  axi_lite_reg_slave_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_data (regs[wr_idx]),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .merged   (wr_merged)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        arready = 1'b1;
        if (arvalid) rd_next = RD_RESP;
      end
      RD_RESP: begin
        if (rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next   = wr_state;
    awready   = 1'b0;
    wready    = 1'b0;
    wr_commit = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end else if (awvalid) begin
          wr_next = WR_ADDR;
        end else if (wvalid) begin
          wr_next = WR_DATA;
        end
      end
      WR_ADDR: begin
        wready = 1'b1;
        if (wvalid) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end
      end
      WR_DATA: begin
        awready = 1'b1;
        if (awvalid) begin
          wr_commit = 1'b1;
          wr_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? regs[rd_idx] : '0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_DECERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (wr_commit) begin
      bvalid <= 1'b1;
      bresp  <= wr_ok ? RESP_OKAY : RESP_DECERR;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit && wr_ok) begin
      regs[wr_idx] <= wr_merged;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized bench for axi_lite_reg_slave against an array-based register model.
// Build with AXIL_REG_SLV_DECERR_EN to check the out-of-window error responses.
module tb_axi_lite_reg_slave;

  localparam int          NR   = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [NR];

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (NR),
    .BASE_ADDR  (BASE)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_decode(input logic [31:0] a, output int idx);
    logic [31:0] off;
    off = a - BASE;
    idx = int'((off / 4) % NR);
`ifdef AXIL_REG_SLV_DECERR_EN
    return off < 4*NR;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] er);
    int idx;
    if (m_decode(a, idx)) begin
      mdl[idx] = m_merge(mdl[idx], d, s);
      er = 2'b00;
    end else begin
      er = 2'b11;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awd,
                          input int wd, input int bhold);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs;
    bit w_hs;
    int cyc = 0;
    logic [1:0] er;
    while (!(aw_done && w_done) && cyc < 30) begin
      @(negedge aclk);
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && cyc >= awd;
      wvalid  = !w_done && cyc >= wd;
      if (w_done && !aw_done) begin
        chk("wfirst_awready", awready, 1);
        chk("wfirst_wready", wready, 0);
      end
      if (aw_done && !w_done) begin
        chk("awfirst_awready", awready, 0);
        chk("awfirst_wready", wready, 1);
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    if (!(aw_done && w_done)) chk("wr_timeout", 0, 1);
    m_write(a, d, s, er);
    @(negedge aclk);
    awvalid = 0;
    wvalid  = 0;
    chk("bvalid_lat", bvalid, 1);
    chk("bresp", bresp, er);
    repeat (bhold) begin
      @(negedge aclk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, er);
    end
    bready = 1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
    chk("wr_idle_awready", awready, 1);
    chk("wr_idle_wready", wready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int idx;
    logic [31:0] ed;
    logic [1:0] er;
    if (m_decode(a, idx)) begin
      ed = mdl[idx];
      er = 2'b00;
    end else begin
      ed = 32'h0;
      er = 2'b11;
    end
    @(negedge aclk);
    araddr  = a;
    arvalid = 1;
    chk("arready_idle", arready, 1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    chk("arready_busy", arready, 0);
    repeat (hold) begin
      @(negedge aclk);
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, ed);
      chk("rresp_hold", rresp, er);
      chk("arready_hold", arready, 0);
    end
    rready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  // Read and write of the same register accepted on one edge
  task automatic do_rw_same(input logic [31:0] a, input logic [31:0] d);
    int idx;
    logic [31:0] ed;
    logic [1:0] rer;
    logic [1:0] wer;
    if (m_decode(a, idx)) begin
      ed  = mdl[idx];
      rer = 2'b00;
    end else begin
      ed  = 32'h0;
      rer = 2'b11;
    end
    @(negedge aclk);
    araddr  = a;
    arvalid = 1;
    awaddr  = a;
    awvalid = 1;
    wdata   = d;
    wstrb   = 4'hF;
    wvalid  = 1;
    chk("rw_arready", arready, 1);
    chk("rw_awready", awready, 1);
    chk("rw_wready", wready, 1);
    @(posedge aclk);
    m_write(a, d, 4'hF, wer);
    @(negedge aclk);
    arvalid = 0;
    awvalid = 0;
    wvalid  = 0;
    chk("rw_rdata_old", rdata, ed);
    chk("rw_rresp", rresp, rer);
    chk("rw_bvalid", bvalid, 1);
    chk("rw_bresp", bresp, wer);
    rready = 1;
    bready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
    bready = 0;
    chk("rw_rvalid_drop", rvalid, 0);
    chk("rw_bvalid_drop", bvalid, 0);
  endtask

  initial begin
    areset_n = 0;
    araddr   = 0;
    arvalid  = 0;
    rready   = 0;
    awaddr   = 0;
    awvalid  = 0;
    wdata    = 0;
    wstrb    = 0;
    wvalid   = 0;
    bready   = 0;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    repeat (3) @(negedge aclk);
    areset_n = 1;

    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h4, 0);

    do_write(32'h8, 32'h12345678, 4'hF, 3, 0, 1);
    do_read(32'h8, 0);

    do_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
    do_write(32'h0, 32'h00000000, 4'b0101, 1, 0, 0);
    do_read(32'h0, 0);

    do_write(32'hC, 32'hA5A55A5A, 4'hF, 0, 0, 0);
    do_read(32'hC, 5);

    do_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 2);
    do_read(32'h10, 1);
    do_read(32'h0, 0);

    do_write(32'h7, 32'hCAFE0001, 4'b1001, 0, 0, 0);
    do_read(32'h5, 0);

    do_rw_same(32'h8, 32'h55AA55AA);
    do_read(32'h8, 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0, 1:
          do_write(a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        2, 3:
          do_read(a, $urandom_range(0, 3));
        default:
          do_rw_same(a, $urandom);
      endcase
    end

    @(negedge aclk);
    awaddr  = 32'h4;
    wdata   = 32'h77777777;
    wstrb   = 4'hF;
    awvalid = 1;
    wvalid  = 1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0;
    wvalid  = 0;
    chk("pre_rst_bvalid", bvalid, 1);
    #2;
    areset_n = 0;
    #1;
    chk("async_rst_bvalid", bvalid, 0);
    chk("async_rst_rvalid", rvalid, 0);
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    @(negedge aclk);
    areset_n = 1;
    for (int i = 0; i < NR; i++) do_read(32'(4*i), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
